// File: rtl/shift_reg_univ.sv
// -----------------------------------------------------------------------------
// shift_reg_univ
//   Parametrised universal shift register: parallel load, shift left, shift
//   right and rotate left. Provides true/complement outputs, a serial output
//   and a saturating shift counter with a registered done flag.
//
//   Parameters
//     WIDTH    register width in bits (>= 2)
//     RST_VAL  value loaded into q on reset
//
//   Ports
//     clk     rising-edge clock
//     rst     synchronous reset, active high
//     d       parallel load data
//     load    parallel load strobe (wins over en)
//     en      shift enable
//     mode    00 hold, 01 shl, 10 shr, 11 rotl
//     sin     serial input bit (unused by rotl)
//     q       register contents
//     qb      bitwise complement of q
//     sout    bit that leaves the register on the next shift in this mode
//     cnt     shifts since last load/reset, saturating at WIDTH
//     done    high once cnt has reached WIDTH, until load or rst
//     parity  (only with SHIFT_REG_UNIV_PARITY_EN defined) registered ^q
//
//   Build option
//     SHIFT_REG_UNIV_PARITY_EN  adds the registered parity output.
// -----------------------------------------------------------------------------
module shift_reg_univ #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           d,
   input  logic                       load,
   input  logic                       en,
   input  logic [1:0]                 mode,
   input  logic                       sin,
   output logic [WIDTH-1:0]           q,
   output logic [WIDTH-1:0]           qb,
   output logic                       sout,
   output logic [$clog2(WIDTH+1)-1:0] cnt,
   output logic                       done
`ifdef SHIFT_REG_UNIV_PARITY_EN
   ,
   output logic                       parity
`endif
);

   localparam int             CW      = $clog2(WIDTH+1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH);

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHL  = 2'b01;
   localparam logic [1:0] MODE_SHR  = 2'b10;
   localparam logic [1:0] MODE_ROTL = 2'b11;

   logic [WIDTH-1:0] q_reg,    q_next;
   logic [CW-1:0]    cnt_reg,  cnt_next;
   logic             done_reg, done_next;

   // Candidate next values for each shift flavour.
   logic [WIDTH-1:0] shl_val, shr_val, rotl_val;

   assign shl_val  = {q_reg[WIDTH-2:0], sin};
   assign shr_val  = {sin, q_reg[WIDTH-1:1]};
   assign rotl_val = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};

   always_comb begin
      q_next    = q_reg;
      cnt_next  = cnt_reg;
      done_next = done_reg;
      if (load) begin
         q_next    = d;
         cnt_next  = '0;
         done_next = 1'b0;
      end else if (en && (mode != MODE_HOLD)) begin
         case (mode)
            MODE_SHL:  q_next = shl_val;
            MODE_SHR:  q_next = shr_val;
            MODE_ROTL: q_next = rotl_val;
            default:   q_next = q_reg;
         endcase
         // Counter saturates at WIDTH; done follows the saturated count so it
         // rises on the same edge cnt reaches WIDTH and then stays put.
         if (cnt_reg < CNT_MAX) begin
            cnt_next = cnt_reg + 1'b1;
         end
         done_next = (cnt_next == CNT_MAX);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_reg    <= RST_VAL;
         cnt_reg  <= '0;
         done_reg <= 1'b0;
      end else begin
         q_reg    <= q_next;
         cnt_reg  <= cnt_next;
         done_reg <= done_next;
      end
   end

   // Complement output, one inverter per bit.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_qb
         assign qb[gi] = ~q_reg[gi];
      end
   endgenerate

   // Serial output shows the bit that the current mode would push out.
   always_comb begin
      case (mode)
         MODE_SHL,
         MODE_ROTL: sout = q_reg[WIDTH-1];
         MODE_SHR:  sout = q_reg[0];
         default:   sout = 1'b0;
      endcase
   end

   assign q    = q_reg;
   assign cnt  = cnt_reg;
   assign done = done_reg;

`ifdef SHIFT_REG_UNIV_PARITY_EN
   // Parity is taken from the next-state value so it is aligned with q.
   logic parity_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         parity_reg <= ^RST_VAL;
      end else begin
         parity_reg <= ^q_next;
      end
   end

   assign parity = parity_reg;
`endif

endmodule

// File: tb/tb_shift_reg_univ.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_univ
//   Self-checking bench for shift_reg_univ (WIDTH=8, RST_VAL=0). Directed
//   sequences followed by random stimulus, all compared against an arithmetic
//   reference model of the register contents, counter and done flag.
// -----------------------------------------------------------------------------
module tb_shift_reg_univ;

   localparam int          W    = 8;
   localparam int          CW   = $clog2(W+1);
   localparam int unsigned MASK = (1 << W) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  d;
   logic          load;
   logic          en;
   logic [1:0]    mode;
   logic          sin;
   logic [W-1:0]  q;
   logic [W-1:0]  qb;
   logic          sout;
   logic [CW-1:0] cnt;
   logic          done;
`ifdef SHIFT_REG_UNIV_PARITY_EN
   logic          parity;
`endif

   always #5 clk = ~clk;

   shift_reg_univ #(
      .WIDTH   (W),
      .RST_VAL (8'h00)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .d      (d),
      .load   (load),
      .en     (en),
      .mode   (mode),
      .sin    (sin),
      .q      (q),
      .qb     (qb),
      .sout   (sout),
      .cnt    (cnt),
      .done   (done)
`ifdef SHIFT_REG_UNIV_PARITY_EN
      ,
      .parity (parity)
`endif
   );

   int checks = 0;
   int errors = 0;
   int txn    = 0;

   // Reference model state.
   int unsigned q_m    = 0;
   int unsigned cnt_m  = 0;
   bit          done_m = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock transaction: drive on the falling edge, check sout before the
   // rising edge, advance the model, then check all state 3 ns after it.
   task automatic cyc(input bit r, input bit l, input bit e, input logic [1:0] m,
                      input bit s, input logic [W-1:0] dv);
      int unsigned sout_m;
      @(negedge clk);
      rst = r; load = l; en = e; mode = m; sin = s; d = dv;
      #1;
      if (m == 2'd1 || m == 2'd3) sout_m = (q_m >> (W-1)) & 1;
      else if (m == 2'd2)         sout_m = q_m & 1;
      else                        sout_m = 0;
      check("sout", 32'(sout), sout_m);

      @(posedge clk);
      if (r) begin
         q_m = 0; cnt_m = 0; done_m = 1'b0;
      end else if (l) begin
         q_m = 32'(dv); cnt_m = 0; done_m = 1'b0;
      end else if (e && m != 2'd0) begin
         case (m)
            2'd1:    q_m = ((q_m << 1) | s) & MASK;
            2'd2:    q_m = (q_m >> 1) | (32'(s) << (W-1));
            default: q_m = ((q_m << 1) | (q_m >> (W-1))) & MASK;
         endcase
         if (cnt_m < W) cnt_m++;
         done_m = (cnt_m == W);
      end
      #3;
      check("q",    32'(q),    q_m);
      check("qb",   32'(qb),   (~q_m) & MASK);
      check("cnt",  32'(cnt),  cnt_m);
      check("done", 32'(done), 32'(done_m));
`ifdef SHIFT_REG_UNIV_PARITY_EN
      check("parity", 32'(parity), $countones(q_m) % 2);
`endif
      $display("txn %0d rst=%0b load=%0b en=%0b mode=%0d sin=%0b d=%h -> q=%h cnt=%0d done=%0b",
               txn, r, l, e, m, s, dv, q, cnt, done);
      txn++;
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; en = 1'b0; mode = 2'd0; sin = 1'b0; d = '0;

      // Reset state.
      cyc(1, 0, 0, 2'd0, 0, 8'h00);
      check("rst_q", 32'(q), 32'h00);
      check("rst_qb", 32'(qb), 32'hFF);

      // Load then three left shifts with sin=1.
      cyc(0, 1, 0, 2'd0, 0, 8'hA5);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 2'd1, 1, 8'h00);

      // Eight right shifts of 81 with sin=0, then a ninth (saturation).
      cyc(0, 1, 0, 2'd0, 0, 8'h81);
      for (int i = 0; i < 8; i++) cyc(0, 0, 1, 2'd2, 0, 8'h00);
      check("shr8_q", 32'(q), 32'h00);
      check("shr8_done", 32'(done), 32'h1);
      cyc(0, 0, 1, 2'd2, 0, 8'h00);
      check("shr9_cnt", 32'(cnt), 32'd8);

      // Rotate left of 81: one step gives 03, eight steps return to 81.
      cyc(0, 1, 0, 2'd0, 0, 8'h81);
      cyc(0, 0, 1, 2'd3, 0, 8'h00);
      check("rotl1_q", 32'(q), 32'h03);
      for (int i = 0; i < 7; i++) cyc(0, 0, 1, 2'd3, 1, 8'h00);
      check("rotl8_q", 32'(q), 32'h81);

      // en with mode 00 holds; en=0 holds regardless of mode.
      cyc(0, 0, 1, 2'd0, 1, 8'h00);
      cyc(0, 0, 0, 2'd1, 1, 8'h00);

      // Simultaneous events.
      cyc(0, 1, 1, 2'd1, 1, 8'h3C);
      cyc(1, 1, 0, 2'd0, 0, 8'h5A);
      cyc(0, 1, 0, 2'd0, 0, 8'hF0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 2'd1, 0, 8'h00);
      cyc(1, 0, 1, 2'd1, 0, 8'h00);

      // Parity-oriented sequence (state checked in every build).
      cyc(0, 1, 0, 2'd0, 0, 8'h07);
      cyc(0, 0, 1, 2'd1, 0, 8'h00);
      cyc(0, 1, 0, 2'd0, 0, 8'h03);

      // Random stimulus.
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 31) == 0),
             ($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)),
             8'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
